// File: rtl/fifo_wptr_full.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_wptr_full                                                           |
// | Write-domain pointer, full/level/almost-full/overflow flags for an       |
// | async FIFO. Optional almost-full comparator: FIFO_ALMOST_FULL_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_wptr_full #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FIFO_DEPTH_BIT = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int ALMOST_FULL_TH = 12
) (
  input  logic                    w_clk,
  input  logic                    w_rst,
  input  logic                    w_en,
  input  logic [FIFO_DEPTH_BIT:0] r_gray_ptr,
  output logic [FIFO_DEPTH_BIT-1:0] write_addr,
  output logic [FIFO_DEPTH_BIT:0] w_gray_ptr,
  output logic                    flag_full,
  output logic                    flag_almost_full,
  output logic [FIFO_DEPTH_BIT:0] w_level,
  output logic                    w_ovf
);

  localparam int N = FIFO_DEPTH_BIT;

  // Parameter legality is checked at elaboration; nothing is built here.
  if (FIFO_DEPTH != (1 << FIFO_DEPTH_BIT)) begin : g_bad_depth
    $error("fifo_wptr_full: FIFO_DEPTH must equal 2**FIFO_DEPTH_BIT");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("fifo_wptr_full: SYNC_STAGES must be >= 2");
  end
  if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > FIFO_DEPTH) begin : g_bad_th
    $error("fifo_wptr_full: ALMOST_FULL_TH out of range");
  end

  logic [N:0] w_bin_q, w_bin_d;
  logic [N:0] gray_q, gray_d;
  logic [N:0] sync_q [SYNC_STAGES];
  logic [N:0] rq_gray, rq_bin;
  logic [N:0] level_q, level_d;
  logic       full_q, full_d;
  logic       ovf_q;
  logic       wr_ok;

  assign wr_ok   = w_en && !full_q;
  assign w_bin_d = w_bin_q + {{N{1'b0}}, wr_ok};
  assign gray_d  = w_bin_d ^ (w_bin_d >> 1);
  assign rq_gray = sync_q[SYNC_STAGES-1];

  always_comb begin
    rq_bin = '0;
    for (int i = 0; i <= N; i++) begin
      rq_bin[i] = ^(rq_gray >> i);
    end
  end

  // Full when the write pointer is exactly one lap ahead of the synced read pointer.
  assign full_d  = (gray_d == {~rq_gray[N:N-1], rq_gray[N-2:0]});
  assign level_d = w_bin_d - rq_bin;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      w_bin_q <= '0;
      gray_q  <= '0;
      full_q  <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      w_bin_q <= w_bin_d;
      gray_q  <= gray_d;
      full_q  <= full_d;
      level_q <= level_d;
      if (w_en && full_q) begin
        ovf_q <= 1'b1;
      end
      sync_q[0] <= r_gray_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [N:0] AF_TH = (N+1)'(ALMOST_FULL_TH);
  logic af_q;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (level_d >= AF_TH);
    end
  end

  assign flag_almost_full = af_q;
`else
  assign flag_almost_full = 1'b0;
`endif

  assign write_addr = w_bin_q[N-1:0];
  assign w_gray_ptr = gray_q;
  assign flag_full  = full_q;
  assign w_level    = level_q;
  assign w_ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_wptr_full                                                        |
// | Self-checking bench: directed scenarios plus randomized traffic against  |
// | an occupancy-based reference model.                                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fifo_wptr_full;

  localparam int DEPTH = 16;
  localparam int NB    = 4;
  localparam int SYNC  = 2;
  localparam int TH    = 12;

  logic          w_clk;
  logic          w_rst;
  logic          w_en;
  logic [NB:0]   r_gray_ptr;
  logic [NB-1:0] write_addr;
  logic [NB:0]   w_gray_ptr;
  logic          flag_full;
  logic          flag_almost_full;
  logic [NB:0]   w_level;
  logic          w_ovf;

  fifo_wptr_full #(
    .FIFO_DEPTH    (DEPTH),
    .FIFO_DEPTH_BIT(NB),
    .SYNC_STAGES   (SYNC),
    .ALMOST_FULL_TH(TH)
  ) dut (
    .w_clk           (w_clk),
    .w_rst           (w_rst),
    .w_en            (w_en),
    .r_gray_ptr      (r_gray_ptr),
    .write_addr      (write_addr),
    .w_gray_ptr      (w_gray_ptr),
    .flag_full       (flag_full),
    .flag_almost_full(flag_almost_full),
    .w_level         (w_level),
    .w_ovf           (w_ovf)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: accepted-write count and reader position, both mod 32;
  // the reader position is seen SYNC edges late.
  int m_wcnt;
  int m_hist [SYNC];
  int m_level;
  bit m_full, m_af, m_ovf;

  function automatic logic [NB:0] to_gray(input int b);
    logic [NB:0] v;
    v = NB'(0) + (NB+1)'(b % 32);
    return v ^ (v >> 1);
  endfunction

  task automatic step(input bit en, input bit rst, input int rbin);
    int rq;
    bit acc;
    @(negedge w_clk);
    w_en       = en;
    w_rst      = rst;
    r_gray_ptr = to_gray(rbin);
    @(posedge w_clk);
    if (rst) begin
      m_wcnt = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
      for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
    end else begin
      rq = m_hist[0];
      for (int i = 0; i < SYNC-1; i++) m_hist[i] = m_hist[i+1];
      m_hist[SYNC-1] = rbin % 32;
      acc = en && !m_full;
      if (en && m_full) m_ovf = 1;
      if (acc) m_wcnt = (m_wcnt + 1) % 32;
      m_level = (m_wcnt - rq + 32) % 32;
      m_full  = (m_level == DEPTH);
`ifdef FIFO_ALMOST_FULL_EN
      m_af    = (m_level >= TH);
`else
      m_af    = 0;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 0);
    step(0, 1, 0);
    n_checks++; if (write_addr !== 4'd0) $display("FAIL reset_addr got %0d exp 0", write_addr); else n_pass++;
    n_checks++; if (w_gray_ptr !== 5'd0) $display("FAIL reset_gray got %b exp 00000", w_gray_ptr); else n_pass++;
    n_checks++; if (flag_full !== 1'b0) $display("FAIL reset_full got %b exp 0", flag_full); else n_pass++;
    n_checks++; if (flag_almost_full !== 1'b0) $display("FAIL reset_af got %b exp 0", flag_almost_full); else n_pass++;
    n_checks++; if (w_level !== 5'd0) $display("FAIL reset_level got %0d exp 0", w_level); else n_pass++;
    n_checks++; if (w_ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", w_ovf); else n_pass++;
  endtask

  task automatic test_fill();
    step(0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0);
      n_checks++;
      if (write_addr !== 4'((i + 1) % 16)) $display("FAIL fill_addr[%0d] got %0d exp %0d", i, write_addr, (i + 1) % 16);
      else n_pass++;
      n_checks++;
      if (flag_full !== (i == 15)) $display("FAIL fill_full[%0d] got %b exp %b", i, flag_full, i == 15);
      else n_pass++;
    end
    n_checks++; if (w_level !== 5'd16) $display("FAIL fill_level got %0d exp 16", w_level); else n_pass++;
    n_checks++; if (w_gray_ptr !== 5'b11000) $display("FAIL fill_gray got %b exp 11000", w_gray_ptr); else n_pass++;
  endtask

  task automatic test_overflow();
    step(1, 0, 0);
    n_checks++; if (write_addr !== 4'd0) $display("FAIL ovf_addr got %0d exp 0", write_addr); else n_pass++;
    n_checks++; if (w_level !== 5'd16) $display("FAIL ovf_level got %0d exp 16", w_level); else n_pass++;
    n_checks++; if (w_ovf !== 1'b1) $display("FAIL ovf_set got %b exp 1", w_ovf); else n_pass++;
    step(0, 0, 0);
    step(0, 0, 0);
    n_checks++; if (w_ovf !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", w_ovf); else n_pass++;
  endtask

  task automatic test_release();
    step(0, 0, 4);
    n_checks++; if (flag_full !== 1'b1) $display("FAIL rel_edge1 got %b exp 1", flag_full); else n_pass++;
    step(0, 0, 4);
    n_checks++; if (flag_full !== 1'b1) $display("FAIL rel_edge2 got %b exp 1", flag_full); else n_pass++;
    step(0, 0, 4);
    n_checks++; if (flag_full !== 1'b0) $display("FAIL rel_edge3 got %b exp 0", flag_full); else n_pass++;
    n_checks++; if (w_level !== 5'd12) $display("FAIL rel_level got %0d exp 12", w_level); else n_pass++;
  endtask

  task automatic test_almost_full();
    bit exp12;
`ifdef FIFO_ALMOST_FULL_EN
    exp12 = 1;
`else
    exp12 = 0;
`endif
    step(0, 1, 0);
    for (int i = 0; i < 11; i++) step(1, 0, 0);
    n_checks++; if (flag_almost_full !== 1'b0) $display("FAIL af_11 got %b exp 0", flag_almost_full); else n_pass++;
    step(1, 0, 0);
    n_checks++; if (flag_almost_full !== exp12) $display("FAIL af_12 got %b exp %b", flag_almost_full, exp12); else n_pass++;
  endtask

  task automatic test_wrap();
    int total;
    bit saw_full;
    total = 0;
    saw_full = 0;
    step(0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, (total >= 2) ? total - 2 : 0);
      total++;
      if (flag_full) saw_full = 1;
      n_checks++;
      if (w_level !== 5'(m_level)) $display("FAIL wrap_level[%0d] got %0d exp %0d", i, w_level, m_level);
      else n_pass++;
    end
    for (int i = 0; i < SYNC + 1; i++) step(0, 0, total - 2);
    n_checks++; if (saw_full) $display("FAIL wrap_nofull got 1 exp 0"); else n_pass++;
    n_checks++; if (w_level !== 5'd2) $display("FAIL wrap_level_final got %0d exp 2", w_level); else n_pass++;
    n_checks++; if (write_addr !== 4'd8) $display("FAIL wrap_addr got %0d exp 8", write_addr); else n_pass++;
    n_checks++; if (w_gray_ptr !== 5'b01100) $display("FAIL wrap_gray got %b exp 01100", w_gray_ptr); else n_pass++;
  endtask

  task automatic test_reset_midfill();
    step(0, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0);
    step(1, 1, 0);
    n_checks++;
    if ({write_addr, w_gray_ptr, flag_full, flag_almost_full, w_level, w_ovf} !== '0)
      $display("FAIL midrst_outputs got addr=%0d gray=%b full=%b af=%b lvl=%0d ovf=%b exp all 0",
               write_addr, w_gray_ptr, flag_full, flag_almost_full, w_level, w_ovf);
    else n_pass++;
    step(1, 0, 0);
    n_checks++; if (write_addr !== 4'd1) $display("FAIL midrst_next_addr got %0d exp 1", write_addr); else n_pass++;
    n_checks++; if (w_level !== 5'd1) $display("FAIL midrst_level got %0d exp 1", w_level); else n_pass++;
  endtask

  task automatic test_random();
    int wr_total, rd_total;
    bit en, rst;
    step(0, 1, 0);
    wr_total = 0;
    rd_total = 0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 99) < 60);
      if (rd_total < wr_total && $urandom_range(0, 99) < 45) rd_total++;
      step(en, rst, rd_total);
      if (rst) begin
        wr_total = 0;
        rd_total = 0;
      end else if (en && write_addr !== 4'(wr_total % 16)) begin
        wr_total = wr_total;
      end
      wr_total = m_wcnt + 32 * (wr_total / 32);
      if (wr_total < rd_total) wr_total += 32;
      n_checks++;
      if (write_addr !== 4'(m_wcnt % 16)) $display("FAIL rnd_addr[%0d] got %0d exp %0d", c, write_addr, m_wcnt % 16);
      else n_pass++;
      n_checks++;
      if (w_gray_ptr !== to_gray(m_wcnt)) $display("FAIL rnd_gray[%0d] got %b exp %b", c, w_gray_ptr, to_gray(m_wcnt));
      else n_pass++;
      n_checks++;
      if (flag_full !== m_full) $display("FAIL rnd_full[%0d] got %b exp %b", c, flag_full, m_full);
      else n_pass++;
      n_checks++;
      if (flag_almost_full !== m_af) $display("FAIL rnd_af[%0d] got %b exp %b", c, flag_almost_full, m_af);
      else n_pass++;
      n_checks++;
      if (w_level !== 5'(m_level)) $display("FAIL rnd_level[%0d] got %0d exp %0d", c, w_level, m_level);
      else n_pass++;
      n_checks++;
      if (w_ovf !== m_ovf) $display("FAIL rnd_ovf[%0d] got %b exp %b", c, w_ovf, m_ovf);
      else n_pass++;
    end
  endtask

  initial begin
    w_en       = 1'b0;
    w_rst      = 1'b1;
    r_gray_ptr = '0;
    m_wcnt = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
    for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_almost_full();
    test_wrap();
    test_reset_midfill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
